seq_detector_prog: RTL and testbench

- Programmable serial-bit sequence detector; parametrised successor to the fixed 3-state detector.
- Pattern and pattern length are loaded at run time, with a selectable overlap mode and a valid-qualified input stream.
- Counts matches in a saturating counter and drives a hex digit plus decimal point onto the 7-segment output bus of the tile top level.

---
 rtl/seq_detector_prog_if.sv | 27 ++
 rtl/seq_detector_prog.sv | 131 +++++++++++++
 tb/tb_seq_detector_prog.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_detector_prog_if.sv
// rtl/seq_detector_prog_if.sv - stream, config and display signals of the programmable sequence detector
interface seq_detector_prog_if #(
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             ena;
  logic             din;
  logic             din_valid;
  logic             cfg_load;
  logic             cfg_bit;
  logic [LEN_W-1:0] cfg_len;
  logic             overlap;
  logic             clr_cnt;
  logic             hit;
  logic [CNT_W-1:0] hit_cnt;
  logic [7:0]       seg;

  modport master (
    output ena, din, din_valid, cfg_load, cfg_bit, cfg_len, overlap, clr_cnt,
    input  hit, hit_cnt, seg
  );

  modport slave (
    input  ena, din, din_valid, cfg_load, cfg_bit, cfg_len, overlap, clr_cnt,
    output hit, hit_cnt, seg
  );
endinterface

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - programmable serial sequence detector with saturating count and 7-seg display
module seq_detector_prog #(
  parameter int                 MAX_LEN = 8,
  parameter int                 LEN_W   = 4,
  parameter int                 CNT_W   = 4,
  parameter int                 RST_LEN = 3,
  parameter logic [MAX_LEN-1:0] RST_PAT = 8'b00000100
) (
  input logic                clk,
  input logic                rst_n,
  seq_detector_prog_if.slave bus
);

  localparam logic [LEN_W-1:0] MAX_LE  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_LE  = LEN_W'(RST_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               len_sel_q, len_sel_d;
  logic               hit_q, hit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         seg_q, seg_d;

  logic [LEN_W-1:0]   le;
  logic [MAX_LEN-1:0] le_mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [LEN_W-1:0]   fill_inc;
  logic               match;
  logic [3:0]         cnt_nib;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'h3F;
      4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;
      4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;
      4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;
      4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;
      4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;
      4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;
      4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;
      default: hex_glyph = 7'h71;
    endcase
  endfunction

  // Display shows the low nibble of the count; narrow counters are zero-extended.
  if (CNT_W >= 4) begin : g_nib_wide
    assign cnt_nib = cnt_d[3:0];
  end else begin : g_nib_narrow
    assign cnt_nib = {{(4-CNT_W){1'b0}}, cnt_d};
  end

  // Next state: config shift, history shift, match on post-shift history, counter and display.
  always_comb begin
    pat_d     = pat_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    len_sel_d = len_sel_q;
    hit_d     = 1'b0;
    cnt_d     = cnt_q;
    match     = 1'b0;

    // Reset length applies until software first programs a pattern.
    if (len_sel_q) le = (bus.cfg_len > MAX_LE) ? MAX_LE : bus.cfg_len;
    else           le = RST_LE;

    for (int i = 0; i < MAX_LEN; i++) le_mask[i] = (LEN_W'(i) < le);

    hist_shift = {hist_q[MAX_LEN-2:0], bus.din};
    fill_inc   = (fill_q >= MAX_LE) ? MAX_LE : fill_q + 1'b1;

    if (bus.cfg_load) begin
      pat_d     = {pat_q[MAX_LEN-2:0], bus.cfg_bit};
      hist_d    = '0;
      fill_d    = '0;
      len_sel_d = 1'b1;
    end else if (bus.din_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      match  = (le != '0) && (fill_inc >= le) &&
               (((hist_shift ^ pat_q) & le_mask) == '0);
      if (match) begin
        hit_d = 1'b1;
        // Without overlap the completing bit must not seed the next match.
        if (!bus.overlap) fill_d = '0;
      end
    end

    if (bus.clr_cnt)                   cnt_d = '0;
    else if (match && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;

    seg_d = {hit_d, hex_glyph(cnt_nib)};
  end

  // State registers; with ena low everything holds except the hit pulse and its decimal point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= RST_PAT;
      hist_q    <= '0;
      fill_q    <= '0;
      len_sel_q <= 1'b0;
      hit_q     <= 1'b0;
      cnt_q     <= '0;
      seg_q     <= 8'h3F;
    end else if (bus.ena) begin
      pat_q     <= pat_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      len_sel_q <= len_sel_d;
      hit_q     <= hit_d;
      cnt_q     <= cnt_d;
      seg_q     <= seg_d;
    end else begin
      hit_q    <= 1'b0;
      seg_q[7] <= 1'b0;
    end
  end

  assign bus.hit     = hit_q;
  assign bus.hit_cnt = cnt_q;
  assign bus.seg     = seg_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - randomized and directed bench for seq_detector_prog against a queue-based model
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_detector_prog_if #(.LEN_W(4), .CNT_W(4)) bus();

  seq_detector_prog #(
    .MAX_LEN(8), .LEN_W(4), .CNT_W(4), .RST_LEN(3), .RST_PAT(8'b00000100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: pattern and history kept as bit lists in arrival order.
  bit pat_m[$];
  bit hist_m[$];
  int fill_m;
  bit seen_m;
  bit hit_m;
  int cnt_m;
  logic [3:0]  cnt4;
  logic [7:0]  exp_seg;
  logic [12:0] got_v, exp_v;
  int hits;

  function automatic void model_reset();
    logic [7:0] rp;
    rp = 8'b00000100;
    pat_m.delete();
    for (int i = MAX_LEN - 1; i >= 0; i--) pat_m.push_back(rp[i]);
    hist_m.delete();
    fill_m = 0;
    seen_m = 0;
    hit_m  = 0;
    cnt_m  = 0;
  endfunction

  function automatic void model_clock();
    int le;
    bit m;
    m     = 0;
    hit_m = 0;
    if (bus.ena) begin
      le = seen_m ? ((int'(bus.cfg_len) > MAX_LEN) ? MAX_LEN : int'(bus.cfg_len)) : 3;
      if (bus.cfg_load) begin
        void'(pat_m.pop_front());
        pat_m.push_back(bus.cfg_bit);
        hist_m.delete();
        fill_m = 0;
        seen_m = 1;
      end else if (bus.din_valid) begin
        hist_m.push_back(bus.din);
        if (hist_m.size() > MAX_LEN) void'(hist_m.pop_front());
        fill_m++;
        if (le != 0 && fill_m >= le) begin
          m = 1;
          for (int i = 0; i < le; i++)
            if (hist_m[hist_m.size() - 1 - i] != pat_m[MAX_LEN - 1 - i]) m = 0;
        end
        if (m) begin
          hit_m = 1;
          if (!bus.overlap) fill_m = 0;
        end
      end
      if (bus.clr_cnt)         cnt_m = 0;
      else if (m && cnt_m < 15) cnt_m++;
    end
    cnt4    = 4'(cnt_m);
    exp_seg = {hit_m, GLYPH[cnt4]};
    exp_v   = {hit_m, cnt4, exp_seg};
  endfunction

  task automatic cyc(input bit ena, input bit din, input bit valid, input bit load,
                     input bit cbit, input logic [3:0] len, input bit ovl, input bit clr);
    bus.ena = ena; bus.din = din; bus.din_valid = valid; bus.cfg_load = load;
    bus.cfg_bit = cbit; bus.cfg_len = len; bus.overlap = ovl; bus.clr_cnt = clr;
    @(posedge clk);
    #1;
    model_clock();
    got_v = {bus.hit, bus.hit_cnt, bus.seg};
    if (bus.hit === 1'b1) hits++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ena = 1'b0; bus.din = 1'b0; bus.din_valid = 1'b0; bus.cfg_load = 1'b0;
    bus.cfg_bit = 1'b0; bus.cfg_len = 4'd3; bus.overlap = 1'b1; bus.clr_cnt = 1'b0;
    #12;
    model_reset();
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", bus.hit); end
    checks++; if (bus.hit_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.hit_cnt); end
    checks++; if (bus.seg !== 8'h3F) begin failures++; $display("FAIL reset_seg got=%h exp=3f", bus.seg); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_default_pattern();
    bit s [4] = '{1, 0, 0, 0};
    bit v [4] = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      cyc(1, s[i], v[i], 0, 0, 4'd3, 1, 0);
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL default_pat[%0d] got=%h exp=%h", i, got_v, exp_v); end
    end
    // got_v was sampled one cycle after the match; reuse the loop's last two samples via explicit checks.
    checks++; if (bus.seg !== 8'h06) begin failures++; $display("FAIL default_seg_after got=%h exp=06", bus.seg); end
    checks++; if (bus.hit_cnt !== 4'd1) begin failures++; $display("FAIL default_cnt got=%0d exp=1", bus.hit_cnt); end
  endtask

  task automatic test_default_dp();
    // Second 1,0,0 after clearing the count: the dp must be lit exactly in the match cycle.
    bit s [3] = '{1, 0, 0};
    cyc(1, 0, 0, 0, 0, 4'd3, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, s[i], 1, 0, 0, 4'd3, 1, 0);
    checks++; if (bus.seg !== 8'h86) begin failures++; $display("FAIL dp_on_hit got=%h exp=86", bus.seg); end
    checks++; if (got_v !== exp_v) begin failures++; $display("FAIL dp_model got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_overlap(input bit ovl);
    bit p [4] = '{1, 0, 1, 1};
    bit s [7] = '{1, 0, 1, 1, 0, 1, 1};
    cyc(1, 0, 0, 0, 0, 4'd4, ovl, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 1, p[i], 4'd4, ovl, 0);
    hits = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(1, s[i], 1, 0, 0, 4'd4, ovl, 0);
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL overlap%0d[%0d] got=%h exp=%h", ovl, i, got_v, exp_v); end
    end
    checks++;
    if (hits != (ovl ? 2 : 1)) begin failures++; $display("FAIL overlap%0d_hits got=%0d exp=%0d", ovl, hits, ovl ? 2 : 1); end
    checks++;
    if (bus.hit_cnt !== (ovl ? 4'd2 : 4'd1)) begin failures++; $display("FAIL overlap%0d_cnt got=%0d exp=%0d", ovl, bus.hit_cnt, ovl ? 2 : 1); end
  endtask

  task automatic test_gaps();
    // Each entry: {ena, valid, din}
    logic [2:0] seq [16] = '{3'b111, 3'b100, 3'b100, 3'b100, 3'b110, 3'b011, 3'b011,
                             3'b100, 3'b100, 3'b100, 3'b110, 3'b100, 3'b100, 3'b100,
                             3'b100, 3'b100};
    bit p [3] = '{1, 0, 0};
    cyc(1, 0, 0, 0, 0, 4'd3, 1, 1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, p[i], 4'd3, 1, 0);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(seq[i][2], seq[i][0], seq[i][1], 0, 0, 4'd3, 1, 0);
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL gaps[%0d] got=%h exp=%h", i, got_v, exp_v); end
    end
    checks++; if (hits != 1) begin failures++; $display("FAIL gaps_hits got=%0d exp=1", hits); end
  endtask

  task automatic test_saturation();
    bit s [3] = '{1, 0, 0};
    cyc(1, 0, 0, 0, 0, 4'd3, 1, 1);
    for (int k = 0; k < 17; k++)
      for (int i = 0; i < 3; i++) begin
        cyc(1, s[i], 1, 0, 0, 4'd3, 1, 0);
        checks++;
        if (got_v !== exp_v) begin failures++; $display("FAIL sat[%0d.%0d] got=%h exp=%h", k, i, got_v, exp_v); end
      end
    checks++; if (bus.hit_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", bus.hit_cnt); end
    checks++; if (bus.seg[6:0] !== 7'h71) begin failures++; $display("FAIL sat_seg got=%h exp=71", bus.seg[6:0]); end
    cyc(1, 1, 1, 0, 0, 4'd3, 1, 0);
    cyc(1, 0, 1, 0, 0, 4'd3, 1, 0);
    cyc(1, 0, 1, 0, 0, 4'd3, 1, 1);
    checks++; if (bus.hit_cnt !== 4'd0) begin failures++; $display("FAIL clr_wins_cnt got=%0d exp=0", bus.hit_cnt); end
    checks++; if (bus.hit !== 1'b1) begin failures++; $display("FAIL clr_wins_hit got=%b exp=1", bus.hit); end
    checks++; if (got_v !== exp_v) begin failures++; $display("FAIL clr_wins_model got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_cfg_clear();
    bit p [3] = '{1, 0, 0};
    logic [7:0] lp, pre;
    hits = 0;
    cyc(1, 1, 1, 0, 0, 4'd3, 1, 0);
    cyc(1, 0, 1, 0, 0, 4'd3, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, p[i], 4'd3, 1, 0);
    cyc(1, 0, 1, 0, 0, 4'd3, 1, 0);
    checks++; if (hits != 0) begin failures++; $display("FAIL cfg_clears_hist got=%0d exp=0", hits); end
    for (int i = 0; i < 6; i++) cyc(1, p[i % 3], 1, 0, 0, 4'd0, 1, 0);
    checks++; if (hits != 0) begin failures++; $display("FAIL len0_hits got=%0d exp=0", hits); end
    lp  = 8'($urandom);
    pre = 8'($urandom);
    for (int i = 7; i >= 0; i--) cyc(1, 0, 0, 1, lp[i], 4'd12, 1, 0);
    for (int i = 7; i >= 0; i--) begin
      cyc(1, pre[i], 1, 0, 0, 4'd12, 1, 0);
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL len12_pre[%0d] got=%h exp=%h", i, got_v, exp_v); end
    end
    for (int i = 7; i >= 0; i--) cyc(1, lp[i], 1, 0, 0, 4'd12, 1, 0);
    checks++; if (bus.hit !== 1'b1) begin failures++; $display("FAIL len12_clamp_hit got=%b exp=1", bus.hit); end
    checks++; if (got_v !== exp_v) begin failures++; $display("FAIL len12_model got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_async_reset();
    bit s [3] = '{1, 0, 0};
    cyc(1, 1, 1, 0, 0, 4'd3, 1, 0);
    cyc(1, 0, 1, 0, 0, 4'd3, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.hit_cnt !== 4'd0) begin failures++; $display("FAIL areset_cnt got=%0d exp=0", bus.hit_cnt); end
    checks++; if (bus.seg !== 8'h3F) begin failures++; $display("FAIL areset_seg got=%h exp=3f", bus.seg); end
    checks++; if (bus.hit !== 1'b0) begin failures++; $display("FAIL areset_hit got=%b exp=0", bus.hit); end
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    cyc(1, 0, 1, 0, 0, 4'd5, 1, 0);
    checks++; if (hits != 0) begin failures++; $display("FAIL areset_no_partial got=%0d exp=0", hits); end
    for (int i = 0; i < 3; i++) begin
      cyc(1, s[i], 1, 0, 0, 4'd5, 1, 0);
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL areset_seq[%0d] got=%h exp=%h", i, got_v, exp_v); end
    end
    checks++; if (bus.hit !== 1'b1) begin failures++; $display("FAIL areset_full_hit got=%b exp=1", bus.hit); end
  endtask

  task automatic test_random();
    logic [3:0] len;
    bit ovl;
    len = 4'd3;
    ovl = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) len = 4'($urandom_range(0, 5) == 0 ? $urandom_range(0, 15) : $urandom_range(1, 4));
      if ($urandom_range(0, 29) == 0) ovl = 1'($urandom);
      cyc($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 9) < 7,
          $urandom_range(0, 19) == 0, 1'($urandom), len, ovl, $urandom_range(0, 39) == 0);
      checks++;
      if (got_v !== exp_v) begin failures++; $display("FAIL random[%0d] got=%h exp=%h", n, got_v, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_default_pattern();
    test_default_dp();
    test_overlap(1'b1);
    test_overlap(1'b0);
    test_gaps();
    test_saturation();
    test_cfg_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
